// File: rtl/fp2int32_seq_if.sv
// Operand/result handshake bundle for the float-to-int32 converter.
// The slave side is the converter; the master side feeds operands and drains results.
interface fp2int32_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_float;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_int;
    logic        out_overflow;
    logic        out_invalid;

    modport master (
        output in_valid,
        output in_float,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_int,
        input  out_overflow,
        input  out_invalid
    );

    modport slave (
        input  in_valid,
        input  in_float,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_int,
        output out_overflow,
        output out_invalid
    );
endinterface

// File: rtl/fp2int32_seq.sv
// Multi-cycle IEEE-754 single to signed 32-bit integer converter (truncation toward zero).
// Mantissa alignment uses a small shifter moving at most SHIFT_STEP bits per cycle.
module fp2int32_seq #(
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    fp2int32_seq_if.slave bus
);

    localparam logic [4:0] Step = 5'(SHIFT_STEP);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q;
    logic        sign_q;
    logic        left_q;
    logic [4:0]  count_q;
    logic [31:0] mag_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] out_int_q;
    logic        out_overflow_q;
    logic        out_invalid_q;

    logic              in_sign;
    logic [7:0]        in_exp;
    logic [22:0]       in_man;
    logic signed [8:0] exp_unb;
    logic signed [8:0] exp_diff;
    logic signed [8:0] exp_ndiff;

    logic        cls_special;
    logic        cls_overflow;
    logic        cls_invalid;
    logic        cls_left;
    logic [31:0] cls_mag;
    logic [4:0]  cls_count;

    logic [4:0]  step_k;
    logic [4:0]  count_next;
    logic [31:0] mag_next;

    function automatic logic [31:0] apply_sign(input logic s, input logic [31:0] m);
        return s ? (~m + 32'd1) : m;
    endfunction

    assign in_sign   = bus.in_float[31];
    assign in_exp    = bus.in_float[30:23];
    assign in_man    = bus.in_float[22:0];
    assign exp_unb   = $signed({1'b0, in_exp}) - 9'sd127;
    assign exp_diff  = exp_unb - 9'sd23;
    assign exp_ndiff = 9'sd23 - exp_unb;

    // Special results are final values; only the normal path is sign-applied later.
    always_comb begin
        cls_special  = 1'b1;
        cls_overflow = 1'b0;
        cls_invalid  = 1'b0;
        cls_left     = 1'b0;
        cls_mag      = 32'd0;
        cls_count    = 5'd0;
        if (in_exp == 8'hff && in_man != 23'd0) begin
            cls_mag     = 32'h8000_0000;
            cls_invalid = 1'b1;
        end else if (in_exp == 8'hff) begin
            cls_mag      = in_sign ? 32'h8000_0000 : 32'h7fff_ffff;
            cls_overflow = 1'b1;
        end else if (in_exp == 8'h00) begin
            cls_mag = 32'd0;
        end else if (exp_unb < 9'sd0) begin
            cls_mag = 32'd0;
        end else if (exp_unb >= 9'sd31) begin
            if (bus.in_float == 32'hcf00_0000) begin
                cls_mag = 32'h8000_0000;
            end else begin
                cls_mag      = in_sign ? 32'h8000_0000 : 32'h7fff_ffff;
                cls_overflow = 1'b1;
            end
        end else begin
            cls_special = 1'b0;
            cls_mag     = {8'b0, 1'b1, in_man};
            cls_left    = (exp_diff >= 9'sd0);
            cls_count   = cls_left ? exp_diff[4:0] : exp_ndiff[4:0];
        end
    end

    always_comb begin
        step_k     = (count_q < Step) ? count_q : Step;
        count_next = count_q - step_k;
        mag_next   = left_q ? (mag_q << step_k) : (mag_q >> step_k);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            sign_q         <= 1'b0;
            left_q         <= 1'b0;
            count_q        <= 5'd0;
            mag_q          <= 32'd0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_int_q      <= 32'd0;
            out_overflow_q <= 1'b0;
            out_invalid_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        sign_q     <= in_sign;
                        mag_q      <= cls_mag;
                        left_q     <= cls_left;
                        count_q    <= cls_count;
                        if (cls_special) begin
                            out_int_q      <= cls_mag;
                            out_overflow_q <= cls_overflow;
                            out_invalid_q  <= cls_invalid;
                            out_valid_q    <= 1'b1;
                            state_q        <= StDone;
                        end else if (cls_count == 5'd0) begin
                            out_int_q   <= apply_sign(in_sign, cls_mag);
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    mag_q   <= mag_next;
                    count_q <= count_next;
                    if (count_next == 5'd0) begin
                        out_int_q   <= apply_sign(sign_q, mag_next);
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q    <= 1'b0;
                        out_int_q      <= 32'd0;
                        out_overflow_q <= 1'b0;
                        out_invalid_q  <= 1'b0;
                        in_ready_q     <= 1'b1;
                        state_q        <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_int      = out_int_q;
    assign bus.out_overflow = out_overflow_q;
    assign bus.out_invalid  = out_invalid_q;

endmodule

// File: tb/tb_fp2int32_seq.sv
// Bench for fp2int32_seq: two instances (SHIFT_STEP 1 and 4) driven through lane arrays,
// directed boundary vectors plus random operands checked against a wide-integer model.
module tb_fp2int32_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp2int32_seq_if bus1 ();
    fp2int32_seq_if bus4 ();

    fp2int32_seq #(.SHIFT_STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fp2int32_seq #(.SHIFT_STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    logic        in_valid  [2];
    logic [31:0] in_float  [2];
    logic        out_ready [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic [31:0] out_int   [2];
    logic        out_ovf   [2];
    logic        out_inv   [2];

    assign bus1.in_valid  = in_valid[0];
    assign bus1.in_float  = in_float[0];
    assign bus1.out_ready = out_ready[0];
    assign in_ready[0]    = bus1.in_ready;
    assign out_valid[0]   = bus1.out_valid;
    assign out_int[0]     = bus1.out_int;
    assign out_ovf[0]     = bus1.out_overflow;
    assign out_inv[0]     = bus1.out_invalid;

    assign bus4.in_valid  = in_valid[1];
    assign bus4.in_float  = in_float[1];
    assign bus4.out_ready = out_ready[1];
    assign in_ready[1]    = bus4.in_ready;
    assign out_valid[1]   = bus4.out_valid;
    assign out_int[1]     = bus4.out_int;
    assign out_ovf[1]     = bus4.out_overflow;
    assign out_inv[1]     = bus4.out_invalid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] f;
        logic [31:0] r;
        logic        ovf;
        logic        inv;
        int          lat1;
        int          lat4;
    } vec_t;

    vec_t dir_vecs [14];

    function automatic int step_of(input int lane);
        return (lane == 0) ? 1 : 4;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: exact value of the float as a wide integer, truncated, then range-checked.
    function automatic void ref_model(input logic [31:0] f, input int step, output logic [31:0] r,
                                      output logic ovf, output logic inv, output int lat);
        logic   s;
        int     e;
        int     ue;
        int     d;
        longint mag;
        longint val;
        s   = f[31];
        e   = int'(f[30:23]);
        ue  = e - 127;
        ovf = 1'b0;
        inv = 1'b0;
        lat = 1;
        r   = 32'd0;
        if (e == 255) begin
            if (f[22:0] != 23'd0) begin
                r   = 32'h8000_0000;
                inv = 1'b1;
            end else begin
                r   = s ? 32'h8000_0000 : 32'h7fff_ffff;
                ovf = 1'b1;
            end
            return;
        end
        if (e == 0) return;
        if (ue > 40) begin
            r   = s ? 32'h8000_0000 : 32'h7fff_ffff;
            ovf = 1'b1;
            return;
        end
        mag = longint'({1'b1, f[22:0]});
        if (ue >= 23) mag = mag << (ue - 23);
        else          mag = mag >> (23 - ue);
        val = s ? -mag : mag;
        if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
            r   = s ? 32'h8000_0000 : 32'h7fff_ffff;
            ovf = 1'b1;
        end else begin
            r = val[31:0];
        end
        if (ue >= 0 && ue <= 30) begin
            d   = (ue >= 23) ? ue - 23 : 23 - ue;
            lat = 1 + (d + step - 1) / step;
        end
    endfunction

    // All tasks enter and leave 1 time unit after a rising edge.
    task automatic send(input int lane, input logic [31:0] f);
        int guard = 0;
        while (!in_ready[lane] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready[lane]) check_eq("in_ready_timeout", 32'(in_ready[lane]), 32'd1);
        in_valid[lane] = 1'b1;
        in_float[lane] = f;
        @(posedge clk); #1;
        in_valid[lane] = 1'b0;
        in_float[lane] = $urandom;
    endtask

    task automatic wait_out(input int lane, output int lat);
        lat = 1;
        while (!out_valid[lane] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out(input int lane, input string tag);
        out_ready[lane] = 1'b1;
        @(posedge clk); #1;
        out_ready[lane] = 1'b0;
        check_eq({tag, "_valid_drop"}, 32'(out_valid[lane]), 32'd0);
        check_eq({tag, "_ready_back"}, 32'(in_ready[lane]), 32'd1);
        check_eq({tag, "_flags_idle"}, {30'd0, out_ovf[lane], out_inv[lane]}, 32'd0);
    endtask

    task automatic run_one(input int lane, input logic [31:0] f, input logic [31:0] r,
                           input logic ovf, input logic inv, input int elat, input string tag);
        int lat;
        send(lane, f);
        wait_out(lane, lat);
        check_eq({tag, "_int"}, out_int[lane], r);
        check_eq({tag, "_ovf"}, 32'(out_ovf[lane]), 32'(ovf));
        check_eq({tag, "_inv"}, 32'(out_inv[lane]), 32'(inv));
        check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
        release_out(lane, tag);
    endtask

    initial begin
        int          lat;
        logic [31:0] f;
        logic [31:0] r;
        logic        ovf;
        logic        inv;
        int          elat;
        int          lane;
        int          hold;
        logic        seen;

        dir_vecs[0]  = '{32'h4408_8000, 32'h0000_0222, 1'b0, 1'b0, 15, 5};
        dir_vecs[1]  = '{32'hc996_5490, 32'hffed_356e, 1'b0, 1'b0, 4, 2};
        dir_vecs[2]  = '{32'h3f80_0000, 32'h0000_0001, 1'b0, 1'b0, 24, 7};
        dir_vecs[3]  = '{32'h4e80_0000, 32'h4000_0000, 1'b0, 1'b0, 8, 3};
        dir_vecs[4]  = '{32'h4f00_0000, 32'h7fff_ffff, 1'b1, 1'b0, 1, 1};
        dir_vecs[5]  = '{32'hcf00_0000, 32'h8000_0000, 1'b0, 1'b0, 1, 1};
        dir_vecs[6]  = '{32'hff80_0000, 32'h8000_0000, 1'b1, 1'b0, 1, 1};
        dir_vecs[7]  = '{32'h7fc0_0000, 32'h8000_0000, 1'b0, 1'b1, 1, 1};
        dir_vecs[8]  = '{32'h3f40_0000, 32'h0000_0000, 1'b0, 1'b0, 1, 1};
        dir_vecs[9]  = '{32'hbf40_0000, 32'h0000_0000, 1'b0, 1'b0, 1, 1};
        dir_vecs[10] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1, 1};
        dir_vecs[11] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1, 1};
        dir_vecs[12] = '{32'h4b7f_ffff, 32'h00ff_ffff, 1'b0, 1'b0, 1, 1};
        dir_vecs[13] = '{32'hceff_ffff, 32'h8000_0080, 1'b0, 1'b0, 8, 3};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_float[i]  = 32'd0;
            out_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            check_eq("reset_in_ready", 32'(in_ready[i]), 32'd1);
            check_eq("reset_out_valid", 32'(out_valid[i]), 32'd0);
            check_eq("reset_out_int", out_int[i], 32'd0);
            check_eq("reset_flags", {30'd0, out_ovf[i], out_inv[i]}, 32'd0);
        end

        for (int i = 0; i < 14; i++) begin
            for (int l = 0; l < 2; l++) begin
                run_one(l, dir_vecs[i].f, dir_vecs[i].r, dir_vecs[i].ovf, dir_vecs[i].inv,
                        (l == 0) ? dir_vecs[i].lat1 : dir_vecs[i].lat4,
                        $sformatf("dir%0d_s%0d", i, step_of(l)));
            end
        end

        // Backpressure: result held, new operand offered while blocked.
        send(0, 32'h4408_8000);
        wait_out(0, lat);
        check_eq("bp_lat", 32'(lat), 32'd15);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                in_valid[0] = 1'b1;
                in_float[0] = 32'h3f80_0000;
            end
            check_eq("bp_valid", 32'(out_valid[0]), 32'd1);
            check_eq("bp_int", out_int[0], 32'h0000_0222);
            check_eq("bp_flags", {30'd0, out_ovf[0], out_inv[0]}, 32'd0);
            check_eq("bp_in_ready", 32'(in_ready[0]), 32'd0);
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check_eq("bp_drop", 32'(out_valid[0]), 32'd0);
        check_eq("bp_not_yet_accepted", 32'(in_ready[0]), 32'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check_eq("bp_accepted", 32'(in_ready[0]), 32'd0);
        wait_out(0, lat);
        check_eq("bp_next_int", out_int[0], 32'h0000_0001);
        check_eq("bp_next_lat", 32'(lat), 32'd24);
        release_out(0, "bp_next");

        // Reset during the fifth shift cycle drops the in-flight result.
        send(0, 32'h3f80_0000);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_in_ready", 32'(in_ready[0]), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check_eq("rst_out_int", out_int[0], 32'd0);
        check_eq("rst_flags", {30'd0, out_ovf[0], out_inv[0]}, 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid[0]) seen = 1'b1;
        end
        check_eq("rst_no_stale", 32'(seen), 32'd0);
        run_one(0, 32'h4408_8000, 32'h0000_0222, 1'b0, 1'b0, 15, "after_rst");

        // Random operands, exponent biased toward the shifting and saturating ranges.
        for (int i = 0; i < 300; i++) begin
            lane = int'($urandom_range(0, 1));
            f = $urandom;
            case ($urandom_range(0, 3))
                0: f[30:23] = 8'($urandom_range(120, 160));
                1: f[30:23] = 8'($urandom_range(100, 157));
                2: f[30:23] = 8'($urandom_range(150, 159));
                default: ;
            endcase
            ref_model(f, step_of(lane), r, ovf, inv, elat);
            send(lane, f);
            wait_out(lane, lat);
            check_eq($sformatf("rand_lat[%08h]", f), 32'(lat), 32'(elat));
            hold = int'($urandom_range(0, 3));
            repeat (hold) begin
                @(posedge clk); #1;
            end
            check_eq($sformatf("rand_int[%08h]", f), out_int[lane], r);
            check_eq($sformatf("rand_flags[%08h]", f), {30'd0, out_ovf[lane], out_inv[lane]},
                     {30'd0, ovf, inv});
            release_out(lane, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp2int32_seq.md
Name: fp2int32_seq

Overview:
- Multi-cycle converter from IEEE-754 single-precision float to signed 32-bit two's-complement integer.
- Rounding is truncation toward zero.
- Inverse of the integer-to-float path; used by the rasteriser wherever float vertex/attribute data must become fixed integer coordinates.
- Uses a valid/ready handshake on both sides.
- Mantissa alignment is done iteratively with a small shifter (SHIFT_STEP bits per cycle), not a full barrel shifter.

Parameters:
SHIFT_STEP, 1, maximum bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  float operand valid
in_ready  output  1  block can accept an operand
in_float  input  32  IEEE-754 single operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_int  output  32  signed integer result
out_overflow  output  1  finite operand outside signed 32-bit range; saturated
out_invalid  output  1  operand was NaN

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; out_int=0; out_overflow=0; out_invalid=0; internal mag/count/sign registers cleared.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register sign s, exp e, mantissa m.
  - Unbiased E = e-127, computed as a signed 9-bit value.
  - Classify in the same cycle (priority order):
    - e=255, m!=0 (NaN): mag result 0x80000000, invalid=1 -> DONE.
    - e=255, m=0 (Inf): saturate -> DONE.
    - e=0 (zero or denormal): 0 -> DONE.
    - E<0 (|x|<1): 0 -> DONE.
    - E>=31: saturate -> DONE. Exactly -2^31 (0xCF000000) yields 0x80000000 with overflow=0.
    - Otherwise: mag = {8'b0,1,m}, dir = left if E>=23 else right, count = |E-23|. Go to SHIFT if count!=0, else DONE.
  - Saturation: s=0 gives 0x7FFFFFFF; s=1 gives 0x80000000; overflow=1 in both cases.
- SHIFT:
  - in_ready=0.
  - Each cycle: k = min(SHIFT_STEP, count); mag shifted by k in dir; count -= k.
  - When the new count is 0, go to DONE.
  - Right shifts discard low bits (truncation). Left shifts never lose set bits, since E<=30.
- DONE:
  - out_valid=1.
  - out_int = s ? -mag : mag, with 32-bit two's complement. Special cases present their stored value directly. Negating a zero result gives 0.
  - Outputs stay stable while out_valid=1 and out_ready=0.
  - On out_ready, next state is IDLE and out_valid drops.
  - in_ready stays 0 during DONE. No accept occurs in the same cycle as the output handshake.
- Latency, counted from the accept edge to out_valid high:
  - 1 cycle for special cases and for E=23.
  - Otherwise 1 + ceil(|E-23|/SHIFT_STEP) cycles.
- Throughput: one conversion in flight at a time.
- rst in any state (including mid-SHIFT, or DONE with out_ready low):
  - Returns to reset values on the next edge.
  - The in-flight result is dropped; no out_valid pulse is produced for it.
- in_float is sampled only at the accept edge. Changes to it during SHIFT/DONE are ignored.
- out_overflow and out_invalid are valid only when out_valid=1, and are held 0 otherwise.

Test Plan:
1. Right-shift magnitude, SHIFT_STEP=1: in_float=0x44088000 (546.0).
   - Required: out_int=0x00000222, flags 0, out_valid exactly 15 cycles after accept.
   - Repeat with SHIFT_STEP=4: out_valid after 5 cycles, same result.
2. Negative value: in_float=0xC9965490 (-1231506.0).
   - Required: out_int=0xFFED356E, out_valid 4 cycles after accept (SHIFT_STEP=1).
   - Also in_float=0x3F800000 -> out_int=1 after 24 cycles.
3. Left-shift and saturation boundaries:
   - 0x4E800000 -> 0x40000000.
   - 0x4F000000 -> 0x7FFFFFFF, overflow=1.
   - 0xCF000000 -> 0x80000000, overflow=0.
   - 0xFF800000 -> 0x80000000, overflow=1.
   - Each after 1 cycle, except 0x4E800000, which takes 1+7/SHIFT_STEP cycles.
4. Specials and truncation:
   - 0x7FC00000 -> 0x80000000, invalid=1.
   - 0x3F400000 (0.75) -> 0.
   - 0xBF400000 (-0.75) -> 0.
   - 0x00000001 (denormal) -> 0.
   - 0x80000000 (-0) -> 0.
   - All with 1-cycle latency and flags 0 except where stated.
5. Backpressure:
   - Hold out_ready=0 for 10 cycles after out_valid on 546.0. Required: out_int and flags stable, in_ready=0 throughout.
   - Assert in_valid with a new operand during this window. Required: not accepted until the cycle after the out_ready handshake.
6. Reset mid-operation: accept 0x3F800000, assert rst for 1 cycle at cycle 5 of SHIFT.
   - Required next cycle: state IDLE, in_ready=1, out_valid=0, outputs 0, no stale result ever emitted.
   - A following 0x44088000 then converts correctly to 0x222.
